jkff_sequencer: RTL and testbench
=================================

# jkff_sequencer

Command sequencer and two-requester arbiter for a dual negative-edge JK flip-flop pair (chip74107-style pins). Requesters issue HOLD/CLEAR/SET/TOGGLE commands per channel. The block arbitrates them round-robin, drives J/K, generates a clean falling edge on the selected channel's clock pin, and tracks the expected state in a shadow register. Optionally it reads the outputs back and flags mismatches.

## Interface
- PULSE_W, 1: cycles FF_N_CP is held low per operation (1..15).
- CLK  in  1  system clock; all logic on rising edge.
- N_RST  in  1  reset, asynchronous, active-low.
- REQ  in  2  REQ[r]: requester r has a command pending.
- REQ_CH  in  2  REQ_CH[r]: target flip-flop channel of requester r.
- REQ_OP  in  4  REQ_OP[2r+1:2r]: op of requester r (00 HOLD, 01 CLEAR, 10 SET, 11 TOGGLE).
- ACK  out  2  one-cycle grant pulse; command sampled this cycle.
- DONE  out  2  one-cycle completion pulse to the granted requester.
- ERR  out  1  sticky readback mismatch flag.
- FF_J, FF_K  out  2  J/K pins per channel.
- FF_N_CP  out  2  active-low clock pins, falling edge triggers.
- FF_N_R  out  2  active-low async reset pins.
- FF_Q, FF_N_Q  in  2  flip-flop outputs.

## Operation
- Reset values, all registered: ACK 0, DONE 0, ERR 0, FF_J 0, FF_K 0, FF_N_CP 2'b11, FF_N_R 2'b00, shadow 2'b00, state IDLE, RR pointer favours requester 0.
- FF_N_R goes 2'b11 on the first CLK after N_RST deasserts. No grant is issued while FF_N_R is low.
- States: IDLE -> SETUP -> LOW -> RISE -> (CHECK) -> IDLE.
- IDLE: J/K = 0, N_CP high.
  - Any REQ: grant one requester, pulse ACK, latch ch/op/requester.
  - Both REQ: grant the requester not granted last. First contention after reset goes to requester 0.
- SETUP, 1 cycle: drive FF_J[ch]/FF_K[ch] from op (HOLD 00, CLEAR 01, SET 10, TOGGLE 11). N_CP still high.
- LOW, PULSE_W cycles: FF_N_CP[ch] low. J/K held stable. Update the shadow on entry: HOLD keeps, CLEAR 0, SET 1, TOGGLE inverts.
- RISE, 1 cycle: FF_N_CP[ch] high, J/K still held. Drop J/K to 0 on leaving.
- CHECK, 1 cycle: set ERR if FF_Q[ch] != shadow[ch] or FF_Q[ch] == FF_N_Q[ch].
- DONE to the latched requester is asserted in the final state of the sequence.
- The untargeted channel never sees N_CP or J/K activity.
- Requesters hold REQ/CH/OP stable until ACK. REQ seen outside IDLE waits; it is never dropped.
- A requester may re-request in the cycle after ACK.
- Reset mid-operation: immediately return to reset values. No DONE is issued and the in-flight op is lost. The shadow matches the flip-flops because FF_N_R is driven low.

## Timing
- ACK at cycle t.
- SETUP at t+1.
- LOW at t+2..t+1+PULSE_W.
- RISE at t+2+PULSE_W.
- CHECK/DONE at t+3+PULSE_W with readback; DONE at t+2+PULSE_W without.
- Next grant is possible the cycle after DONE. Throughput is one op per PULSE_W+4 cycles (PULSE_W+3 without readback).
- J/K have at least 1 cycle of setup before the falling edge and at least PULSE_W+1 cycles of hold after it.

## Configuration
- JKSEQ_READBACK_EN defined:
  - CHECK state exists.
  - FF_Q/FF_N_Q are compared and ERR can set.
- JKSEQ_READBACK_EN undefined:
  - No CHECK state; DONE is issued in RISE.
  - ERR tied to 0; FF_Q/FF_N_Q unused.

## Structure
- Package jkseq_pkg:
  - state enum (S_IDLE, S_SETUP, S_LOW, S_RISE, S_CHECK).
  - op enum (OP_HOLD, OP_CLEAR, OP_SET, OP_TOGGLE).
  - PULSE_W counter width constant.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], advance strobe.
  - Outputs: one-hot grant.
  - Pointer reset to favour 0.

## Test plan
- Reset release, PULSE_W=1: FF_N_R 00 -> 11 one cycle after N_RST rises. A REQ[0] held during reset gets ACK no earlier than the cycle after that.
- Requester 0: SET ch0 -> ACK t, FF_J[0]=1/FF_K[0]=0 at t+1, FF_N_CP[0] low at t+2, DONE[0] at t+4. Q[0]=1, ERR 0, FF_N_CP[1] constant 1.
- Both requesters continuously: r0 TOGGLE ch1, r1 CLEAR ch0 -> grants alternate r0, r1, r0, r1 every PULSE_W+4 cycles. Shadow/Q track, ERR stays 0.
- PULSE_W=3: TOGGLE ch0 from 0 -> FF_N_CP[0] low exactly 3 cycles, Q[0]=1, DONE at t+6.
- Readback: force FF_Q[1] stuck 0, SET ch1 -> ERR=1 in CHECK, stays 1 through later ops until N_RST.
- N_RST pulsed low during LOW of a SET -> no DONE, FF_N_CP 11, FF_N_R 00, shadow 00. Next SET after release completes normally.

Source files
------------

// File: rtl/jkseq_pkg.sv
// Shared types for the JK flip-flop command sequencer: FSM states, command
// opcodes, the pulse-width counter width and the shadow-state update rule.
package jkseq_pkg;

    localparam int PW_CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_RISE,
        S_CHECK
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    // Mirrors what a 74107 does with J/K on a falling clock edge.
    function automatic logic next_shadow(input logic cur, input op_t op);
        case (op)
            OP_HOLD:  return cur;
            OP_CLEAR: return 1'b0;
            OP_SET:   return 1'b1;
            default:  return ~cur;
        endcase
    endfunction

endpackage

// File: rtl/jkff_sequencer_if.sv
// Requester handshake plus flip-flop pin bundle; the sequencer sits on the
// slave side, requesters and the external flip-flop pair on the master side.
interface jkff_sequencer_if;

    logic [1:0] req;
    logic [1:0] req_ch;
    logic [3:0] req_op;
    logic [1:0] ack;
    logic [1:0] done;
    logic       err;
    logic [1:0] ff_j;
    logic [1:0] ff_k;
    logic [1:0] ff_n_cp;
    logic [1:0] ff_n_r;
    logic [1:0] ff_q;
    logic [1:0] ff_n_q;

    modport master (
        output req, req_ch, req_op, ff_q, ff_n_q,
        input  ack, done, err, ff_j, ff_k, ff_n_cp, ff_n_r
    );

    modport slave (
        input  req, req_ch, req_op, ff_q, ff_n_q,
        output ack, done, err, ff_j, ff_k, ff_n_cp, ff_n_r
    );

endinterface

// File: rtl/jkff_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that was not granted last (requester 0 after reset).
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic       r_prio1;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = i_req;
        if (i_req == 2'b11) begin
            w_grant = r_prio1 ? 2'b10 : 2'b01;
        end
    end

    assign o_grant = w_grant;

    // Whoever was just granted loses the next tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio1 <= 1'b0;
        end else if (i_advance && (w_grant != 2'b00)) begin
            r_prio1 <= w_grant[0];
        end
    end

endmodule

// File: rtl/jkff_sequencer.sv
// Sequencer for a dual negative-edge JK flip-flop pair: arbitrates requester
// commands, drives J/K and a clean clock pulse, and tracks a shadow state.
// Define JKSEQ_READBACK_EN to add the CHECK state and the sticky ERR flag.
module jkff_sequencer
    import jkseq_pkg::*;
#(
    parameter int PULSE_W = 1
) (
    input  logic            i_clk,
    input  logic            i_n_rst,
    jkff_sequencer_if.slave bus
);

    state_t              r_state;
    logic [PW_CNT_W-1:0] r_cnt;
    logic                r_ch;
    op_t                 r_op;
    logic                r_req;
    logic [1:0]          r_ack;
    logic [1:0]          r_done;
    logic                r_err;
    logic [1:0]          r_j;
    logic [1:0]          r_k;
    logic [1:0]          r_n_cp;
    logic [1:0]          r_n_r;
    logic [1:0]          r_shadow;

    logic [1:0]          w_grant;
    logic                w_advance;

    // Grants only happen from IDLE once the flip-flops are out of reset.
    assign w_advance = (r_state == S_IDLE) && (r_n_r == 2'b11) && (bus.req != 2'b00);

    rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_n_rst),
        .i_req     (bus.req),
        .i_advance (w_advance),
        .o_grant   (w_grant)
    );

`ifndef JKSEQ_READBACK_EN
    logic w_unused_q;
    assign w_unused_q = ^{bus.ff_q, bus.ff_n_q};
`endif

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ch     <= 1'b0;
            r_op     <= OP_HOLD;
            r_req    <= 1'b0;
            r_ack    <= 2'b00;
            r_done   <= 2'b00;
            r_err    <= 1'b0;
            r_j      <= 2'b00;
            r_k      <= 2'b00;
            r_n_cp   <= 2'b11;
            r_n_r    <= 2'b00;
            r_shadow <= 2'b00;
        end else begin
            r_n_r  <= 2'b11;
            r_ack  <= 2'b00;
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    r_j    <= 2'b00;
                    r_k    <= 2'b00;
                    r_n_cp <= 2'b11;
                    if (w_advance) begin
                        r_ack   <= w_grant;
                        r_req   <= w_grant[1];
                        r_ch    <= w_grant[1] ? bus.req_ch[1] : bus.req_ch[0];
                        r_op    <= op_t'(w_grant[1] ? bus.req_op[3:2] : bus.req_op[1:0]);
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_j[r_ch] <= r_op[1];
                    r_k[r_ch] <= r_op[0];
                    r_cnt     <= '0;
                    r_state   <= S_LOW;
                end
                S_LOW: begin
                    r_n_cp[r_ch] <= 1'b0;
                    if (r_cnt == '0) begin
                        r_shadow[r_ch] <= next_shadow(r_shadow[r_ch], r_op);
                    end
                    if (r_cnt == PW_CNT_W'(PULSE_W - 1)) begin
                        r_state <= S_RISE;
                    end else begin
                        r_cnt <= r_cnt + PW_CNT_W'(1);
                    end
                end
                S_RISE: begin
                    r_n_cp <= 2'b11;
`ifdef JKSEQ_READBACK_EN
                    r_state <= S_CHECK;
`else
                    r_done  <= r_req ? 2'b10 : 2'b01;
                    r_state <= S_IDLE;
`endif
                end
`ifdef JKSEQ_READBACK_EN
                // Q must equal the shadow and be complementary to /Q.
                S_CHECK: begin
                    r_j    <= 2'b00;
                    r_k    <= 2'b00;
                    r_done <= r_req ? 2'b10 : 2'b01;
                    if ((bus.ff_q[r_ch] != r_shadow[r_ch]) ||
                        (bus.ff_q[r_ch] == bus.ff_n_q[r_ch])) begin
                        r_err <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack     = r_ack;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.ff_j    = r_j;
    assign bus.ff_k    = r_k;
    assign bus.ff_n_cp = r_n_cp;
    assign bus.ff_n_r  = r_n_r;

endmodule

// File: tb/tb_jkff_sequencer.sv
// Directed bench for jkff_sequencer: two DUTs (PULSE_W 1 and 3) each driving
// a behavioural 74107 pair; readback checks follow JKSEQ_READBACK_EN.
module tb_jkff_sequencer;
    import jkseq_pkg::*;

`ifdef JKSEQ_READBACK_EN
    localparam int DONE_EXTRA = 3;
`else
    localparam int DONE_EXTRA = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic stuck = 1'b0;

    int checks = 0;
    int failures = 0;
    int pwV [2] = '{1, 3};

    logic [1:0] reqV [2] = '{2'b00, 2'b00};
    logic [1:0] chV  [2] = '{2'b00, 2'b00};
    logic [3:0] opV  [2] = '{4'b0000, 4'b0000};

    logic [1:0] ackV  [2];
    logic [1:0] doneV [2];
    logic       errV  [2];
    logic [1:0] jV    [2];
    logic [1:0] kV    [2];
    logic [1:0] nCpV  [2];
    logic [1:0] nRV   [2];
    logic [1:0] qV    [2];
    logic       qM    [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    jkff_sequencer_if ifA ();
    jkff_sequencer_if ifB ();

    jkff_sequencer #(.PULSE_W(1)) dutA (.i_clk(clk), .i_n_rst(rst_n), .bus(ifA));
    jkff_sequencer #(.PULSE_W(3)) dutB (.i_clk(clk), .i_n_rst(rst_n), .bus(ifB));

    always #5 clk = ~clk;

    assign ifA.req    = reqV[0];
    assign ifA.req_ch = chV[0];
    assign ifA.req_op = opV[0];
    assign ifB.req    = reqV[1];
    assign ifB.req_ch = chV[1];
    assign ifB.req_op = opV[1];

    assign qV[0] = {qM[1], qM[0]};
    assign qV[1] = {qM[3], qM[2]};
    assign ifA.ff_q   = qV[0] & {~stuck, 1'b1};
    assign ifA.ff_n_q = ~qV[0];
    assign ifB.ff_q   = qV[1];
    assign ifB.ff_n_q = ~qV[1];

    assign ackV[0]  = ifA.ack;     assign ackV[1]  = ifB.ack;
    assign doneV[0] = ifA.done;    assign doneV[1] = ifB.done;
    assign errV[0]  = ifA.err;     assign errV[1]  = ifB.err;
    assign jV[0]    = ifA.ff_j;    assign jV[1]    = ifB.ff_j;
    assign kV[0]    = ifA.ff_k;    assign kV[1]    = ifB.ff_k;
    assign nCpV[0]  = ifA.ff_n_cp; assign nCpV[1]  = ifB.ff_n_cp;
    assign nRV[0]   = ifA.ff_n_r;  assign nRV[1]   = ifB.ff_n_r;

    // Behavioural 74107: async clear on /R low, J/K acted on at /CP falling edge.
    for (genvar d = 0; d < 2; d++) begin : g_dev
        for (genvar c = 0; c < 2; c++) begin : g_ch
            always @(negedge nCpV[d][c] or negedge nRV[d][c]) begin
                if (!nRV[d][c]) begin
                    qM[d*2+c] <= 1'b0;
                end else begin
                    case ({jV[d][c], kV[d][c]})
                        2'b01:   qM[d*2+c] <= 1'b0;
                        2'b10:   qM[d*2+c] <= 1'b1;
                        2'b11:   qM[d*2+c] <= ~qM[d*2+c];
                        default: qM[d*2+c] <= qM[d*2+c];
                    endcase
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one command, then follow it through every phase to DONE.
    task automatic applyStimulus(input int sel, input int r, input logic ch, input logic [1:0] op,
                                 input logic [1:0] expQ, input logic expErr);
        int lat;
        int lowCnt;
        bit gotAck;
        bit gotDone;
        bit quiet;
        logic [1:0] jExp;
        logic [1:0] kExp;
        lat = 0; lowCnt = 0; gotAck = 0; gotDone = 0; quiet = 1;
        reqV[sel][r] = 1'b1;
        chV[sel][r] = ch;
        opV[sel][2*r +: 2] = op;
        for (int i = 0; i < 30 && !gotAck; i++) begin
            @(negedge clk);
            gotAck = (ackV[sel] != 2'b00);
        end
        checkOutput("ackSeen", 32'(gotAck), 1);
        if (!gotAck) begin
            reqV[sel][r] = 1'b0;
            return;
        end
        checkOutput("ackOneHot", 32'(ackV[sel]), 32'(2'b01 << r));
        reqV[sel][r] = 1'b0;
        @(negedge clk);
        jExp = op[1] ? (2'b01 << ch) : 2'b00;
        kExp = op[0] ? (2'b01 << ch) : 2'b00;
        checkOutput("setupPins", 32'({jV[sel], kV[sel], nCpV[sel]}), 32'({jExp, kExp, 2'b11}));
        lat = 1;
        for (int i = 0; i < 30 && !gotDone; i++) begin
            @(negedge clk);
            lat++;
            if (nCpV[sel][ch] == 1'b0) lowCnt++;
            if (nCpV[sel][~ch] !== 1'b1 || jV[sel][~ch] !== 1'b0 || kV[sel][~ch] !== 1'b0) quiet = 0;
            gotDone = (doneV[sel] != 2'b00);
        end
        checkOutput("doneSeen", 32'(gotDone), 1);
        checkOutput("doneLatency", 32'(lat), 32'(pwV[sel] + DONE_EXTRA));
        checkOutput("doneOneHot", 32'(doneV[sel]), 32'(2'b01 << r));
        checkOutput("lowCycles", 32'(lowCnt), 32'(pwV[sel]));
        checkOutput("otherChQuiet", 32'(quiet), 1);
        checkOutput("qAfter", 32'(qV[sel]), 32'(expQ));
        checkOutput("errAfter", 32'(errV[sel]), 32'(expErr));
        @(negedge clk);
        checkOutput("donePulse", 32'(doneV[sel]), 0);
    endtask

    typedef struct {
        int         r;
        logic       ch;
        logic [1:0] op;
        logic [1:0] expQ;
    } vec_t;

    vec_t vecs [8];
    logic [1:0] rrQExp [4] = '{2'b10, 2'b10, 2'b00, 2'b00};

    initial begin
        bit   got;
        int   nAck;
        int   nDone;
        int   cyc;
        int   lastAck;
        int   doneSeenCnt;

        vecs[0] = '{0, 1'b0, OP_SET,    2'b01};
        vecs[1] = '{1, 1'b1, OP_TOGGLE, 2'b11};
        vecs[2] = '{0, 1'b0, OP_CLEAR,  2'b10};
        vecs[3] = '{1, 1'b1, OP_HOLD,   2'b10};
        vecs[4] = '{0, 1'b0, OP_TOGGLE, 2'b11};
        vecs[5] = '{1, 1'b1, OP_TOGGLE, 2'b01};
        vecs[6] = '{0, 1'b0, OP_HOLD,   2'b01};
        vecs[7] = '{1, 1'b0, OP_CLEAR,  2'b00};

        // Reset, with requester 0 already asking for SET ch0.
        #2 rst_n = 1'b0;
        reqV[0] = 2'b01;
        chV[0]  = 2'b00;
        opV[0]  = 4'b0010;
        repeat (3) @(negedge clk);
        checkOutput("resetState",
                    32'({ackV[0], doneV[0], errV[0], jV[0], kV[0], nCpV[0], nRV[0]}),
                    32'({2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00}));
        rst_n = 1'b1;
        #1 checkOutput("nrHeldLow", 32'(nRV[0]), 32'(2'b00));
        @(negedge clk);
        checkOutput("nrReleased", 32'(nRV[0]), 32'(2'b11));
        checkOutput("noEarlyAck", 32'(ackV[0]), 0);
        @(negedge clk);
        checkOutput("firstAck", 32'(ackV[0]), 32'(2'b01));
        reqV[0] = 2'b00;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (doneV[0] != 2'b00);
        end
        checkOutput("firstDone", 32'(got), 1);
        checkOutput("firstQ", 32'(qV[0]), 32'(2'b01));
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, vecs[i].r, vecs[i].ch, vecs[i].op, vecs[i].expQ, 1'b0);
        end

        // Both requesters held: r0 TOGGLE ch1, r1 CLEAR ch0; grants must alternate.
        chV[0]  = 2'b01;
        opV[0]  = 4'b0111;
        reqV[0] = 2'b11;
        nAck = 0; nDone = 0; cyc = 0; lastAck = 0;
        for (int i = 0; i < 80 && nDone < 4; i++) begin
            @(negedge clk);
            cyc++;
            if (ackV[0] != 2'b00 && nAck < 4) begin
                checkOutput("rrOrder", 32'(ackV[0]), (nAck % 2 == 0) ? 32'h1 : 32'h2);
                if (nAck > 0) checkOutput("rrSpacing", 32'(cyc - lastAck), 32'(pwV[0] + DONE_EXTRA + 1));
                lastAck = cyc;
                nAck++;
                if (nAck == 4) reqV[0] = 2'b00;
            end
            if (doneV[0] != 2'b00) begin
                checkOutput("rrQ", 32'(qV[0]), 32'(rrQExp[nDone]));
                nDone++;
            end
        end
        reqV[0] = 2'b00;
        checkOutput("rrDoneCount", 32'(nDone), 4);
        checkOutput("rrErr", 32'(errV[0]), 0);
        @(negedge clk);

        // Wider pulse on the second device.
        applyStimulus(1, 0, 1'b0, OP_TOGGLE, 2'b01, 1'b0);

`ifdef JKSEQ_READBACK_EN
        stuck = 1'b1;
        applyStimulus(0, 0, 1'b1, OP_SET, 2'b10, 1'b1);
        applyStimulus(0, 1, 1'b0, OP_SET, 2'b11, 1'b1);
        stuck = 1'b0;
`endif

        // Reset pulsed while a SET is in its LOW phase.
        reqV[0][0] = 1'b1;
        chV[0][0]  = 1'b0;
        opV[0][1:0] = OP_SET;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = (ackV[0] != 2'b00);
        end
        checkOutput("midAck", 32'(got), 1);
        reqV[0] = 2'b00;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midLow", 32'(nCpV[0]), 32'(2'b10));
        rst_n = 1'b0;
        #1;
        checkOutput("midResetPins",
                    32'({nCpV[0], nRV[0], ackV[0], doneV[0], jV[0], kV[0], errV[0]}),
                    32'({2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0}));
        checkOutput("midResetQ", 32'(qV[0]), 0);
        doneSeenCnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (doneV[0] != 2'b00) doneSeenCnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (doneV[0] != 2'b00) doneSeenCnt++;
        end
        checkOutput("noDoneAfterReset", 32'(doneSeenCnt), 0);
        checkOutput("nrAfterMidReset", 32'(nRV[0]), 32'(2'b11));
        applyStimulus(0, 0, 1'b0, OP_SET, 2'b01, 1'b0);
        applyStimulus(0, 1, 1'b1, OP_TOGGLE, 2'b11, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
